// File: rtl/tmds_link_sequencer.sv
// -----------------------------------------------------------------------------
// tmds_link_sequencer
//
// Pixel-clock-domain controller feeding the three 10:1 TMDS serializers.
// Brings the link up in four steps: IDLE -> WARMUP (control tokens for
// WARMUP_CYCLES clocks) -> WAIT_VS (wait for a frame boundary) -> RUN (video
// words while DE is high, HSYNC/VSYNC control tokens while DE is low).
//
// Optional feature macro: HDMI_GUARD_EN
//   When defined, the video/sync path is delayed by 10 stages (latency 11) so
//   that 8 preamble + 2 guard-band words can be inserted ahead of every DE
//   burst that follows a blanking gap of at least 12 cycles.
//   When undefined, the block is a plain DVI token/video multiplexer with a
//   latency of one clock.
//
// Parameters:
//   WARMUP_CYCLES  control-token clocks sent before frame alignment (1..65535)
//   VS_POL         active level of vsync_in (1 = active high)
//
// Ports:
//   pixel_clk                  pixel clock
//   rst_n                      synchronous reset, active low
//   enable                     link enable request
//   de_in, hsync_in, vsync_in  video timing, aligned with the video words
//   tmds_vid_ch0/1/2           pre-encoded 10-bit video words (blue/green/red)
//   tmds_ch0/1/2               registered parallel words to the serializers
//   tmds_oe                    pad output enable
//   link_up                    high while in RUN
// -----------------------------------------------------------------------------
module tmds_link_sequencer #(
  parameter int WARMUP_CYCLES = 1024,
  parameter bit VS_POL        = 1'b1
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] tmds_vid_ch0,
  input  logic [9:0] tmds_vid_ch1,
  input  logic [9:0] tmds_vid_ch2,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2,
  output logic       tmds_oe,
  output logic       link_up
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, WAIT_VS, RUN} state_t;

  // One sample of the video/sync stream.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [9:0] c0;
    logic [9:0] c1;
    logic [9:0] c2;
  } px_t;

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    logic [9:0] tok;
    case ({c1, c0})
      2'b00:   tok = TOK_00;
      2'b01:   tok = TOK_01;
      2'b10:   tok = TOK_10;
      default: tok = TOK_11;
    endcase
    return tok;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] warm_cnt;
  logic        vs_prev;
  logic        vs_act;
  logic        vs_edge;
  px_t         px_in;
  px_t         px_out;

  logic [9:0]  ch0_d, ch1_d, ch2_d;
  logic        oe_d, up_d;

  assign px_in = '{de: de_in, hs: hsync_in, vs: vsync_in,
                   c0: tmds_vid_ch0, c1: tmds_vid_ch1, c2: tmds_vid_ch2};

  // VSYNC edge = transition into the active level. The history register is
  // updated in every state, so an edge on the last WARMUP cycle is seen.
  assign vs_act  = (vsync_in == VS_POL);
  assign vs_edge = vs_act && !vs_prev;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples values from before the edge; combinational blocks use blocking.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      warm_cnt <= '0;
      vs_prev  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_prev <= vs_act;
      if (state_q == WARMUP && state_d == WARMUP) warm_cnt <= warm_cnt + 16'd1;
      else                                        warm_cnt <= '0;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = WARMUP;
      // A VSYNC edge coinciding with the final warm-up cycle goes straight to
      // RUN, so that frame boundary is not lost.
      WARMUP:  if (warm_cnt == WARM_LAST) state_d = vs_edge ? RUN : WAIT_VS;
      WAIT_VS: if (vs_edge) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (!enable) state_d = IDLE;
  end

  // --------------------------------------------------------------------------
  // Video/sync path
  // --------------------------------------------------------------------------
`ifdef HDMI_GUARD_EN
  localparam logic [9:0] GB_0 = 10'b1011001100;
  localparam logic [9:0] GB_1 = 10'b0100110011;
  localparam logic [9:0] GB_2 = 10'b1011001100;

  localparam px_t PX_RESET = '{de: 1'b0, hs: 1'b0, vs: !VS_POL,
                               c0: '0, c1: '0, c2: '0};

  px_t        dly [10];
  logic [3:0] gap_cnt;   // consecutive DE-low input cycles, saturating
  logic [3:0] ins_cnt;   // remaining insertion slots after the first
  logic       burst_start;
  logic       ins_active;
  logic       ins_guard;

  // A qualified burst start is seen at the input while the 10 samples ahead
  // of it are still in the delay line; they are replaced on the way out.
  assign burst_start = (state_q == RUN) && de_in && !dly[0].de &&
                       (gap_cnt >= 4'd12);
  assign ins_active  = burst_start || (ins_cnt != 4'd0);
  // Slot index is 10 - ins_cnt; slots 8 and 9 carry the guard band.
  assign ins_guard   = !burst_start && (ins_cnt <= 4'd2);
  assign px_out      = dly[9];

  // NOTE: the delay line is a shift register, not a RAM, and is cleared on
  // reset so no stale video leaks out after the link restarts.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) dly[i] <= PX_RESET;
      gap_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      dly[0] <= px_in;
      for (int i = 1; i < 10; i++) dly[i] <= dly[i-1];

      if (de_in)                 gap_cnt <= '0;
      else if (gap_cnt != 4'hF)  gap_cnt <= gap_cnt + 4'd1;

      if (state_q != RUN)        ins_cnt <= '0;
      else if (burst_start)      ins_cnt <= 4'd9;
      else if (ins_cnt != 4'd0)  ins_cnt <= ins_cnt - 4'd1;
    end
  end
`else
  assign px_out = px_in;
`endif

  always_comb begin
    ch0_d = TOK_00;
    ch1_d = TOK_00;
    ch2_d = TOK_00;
    oe_d  = 1'b0;
    up_d  = 1'b0;
    case (state_q)
      IDLE: ;
      WARMUP, WAIT_VS: begin
        oe_d  = 1'b1;
        ch0_d = ctrl_token(px_out.vs, px_out.hs);
      end
      default: begin
        oe_d = 1'b1;
        up_d = 1'b1;
        if (px_out.de) begin
          ch0_d = px_out.c0;
          ch1_d = px_out.c1;
          ch2_d = px_out.c2;
        end else begin
          ch0_d = ctrl_token(px_out.vs, px_out.hs);
        end
`ifdef HDMI_GUARD_EN
        if (ins_active) begin
          if (ins_guard) begin
            ch0_d = GB_0;
            ch1_d = GB_1;
            ch2_d = GB_2;
          end else begin
            ch0_d = ctrl_token(px_out.vs, px_out.hs);
            ch1_d = TOK_01;
            ch2_d = TOK_00;
          end
        end
`endif
      end
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      tmds_ch0 <= TOK_00;
      tmds_ch1 <= TOK_00;
      tmds_ch2 <= TOK_00;
      tmds_oe  <= 1'b0;
      link_up  <= 1'b0;
    end else begin
      tmds_ch0 <= ch0_d;
      tmds_ch1 <= ch1_d;
      tmds_ch2 <= ch2_d;
      tmds_oe  <= oe_d;
      link_up  <= up_d;
    end
  end

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tmds_link_sequencer
//
// Directed bench for tmds_link_sequencer with WARMUP_CYCLES = 16. A second
// instance with VS_POL = 0 receives the inverted vsync, so it must follow the
// same state timing, triggering on falling edges of its own vsync_in.
// Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_tmds_link_sequencer;

  localparam int W = 16;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst_n, enable, de, hs, vs, vs_n;
  logic [9:0] v0, v1, v2;
  logic [9:0] ch0, ch1, ch2, n_ch0, n_ch1, n_ch2;
  logic       oe, lu, n_oe, n_lu;

  int checks = 0;
  int errors = 0;

  assign vs_n = ~vs;

  always #5 clk = ~clk;

  tmds_link_sequencer #(.WARMUP_CYCLES(W), .VS_POL(1'b1)) dut (
    .pixel_clk(clk), .rst_n(rst_n), .enable(enable), .de_in(de),
    .hsync_in(hs), .vsync_in(vs),
    .tmds_vid_ch0(v0), .tmds_vid_ch1(v1), .tmds_vid_ch2(v2),
    .tmds_ch0(ch0), .tmds_ch1(ch1), .tmds_ch2(ch2),
    .tmds_oe(oe), .link_up(lu)
  );

  tmds_link_sequencer #(.WARMUP_CYCLES(W), .VS_POL(1'b0)) dut_n (
    .pixel_clk(clk), .rst_n(rst_n), .enable(enable), .de_in(de),
    .hsync_in(hs), .vsync_in(vs_n),
    .tmds_vid_ch0(v0), .tmds_vid_ch1(v1), .tmds_vid_ch2(v2),
    .tmds_ch0(n_ch0), .tmds_ch1(n_ch1), .tmds_ch2(n_ch2),
    .tmds_oe(n_oe), .link_up(n_lu)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enable from IDLE and walk through WARMUP and WAIT_VS into RUN.
  // edge_last = 0: a stray VSYNC pulse three cycles before warm-up ends must
  //                be ignored; the real edge arrives in WAIT_VS together with
  //                a DE-high word that must still leave as a sync token.
  // edge_last = 1: the VSYNC edge lands exactly on the last warm-up cycle.
  task automatic bring_up(input bit edge_last);
    enable = 1'b1;
    hs     = 1'b1;
    step();
    check("en_oe_low", oe, 0);
    for (int i = 1; i <= W; i++) begin
      vs = edge_last ? (i == W) : (i == W - 3);
      de = (i == 1);
      v0 = 10'h155; v1 = 10'h2AA; v2 = 10'h0F0;
      step();
      check("warm_oe", oe, 1);
      check("warm_lu", lu, 0);
      check("warm_lu_n", n_lu, 0);
`ifndef HDMI_GUARD_EN
      if (i == 1) check("warm_sync_ch0", ch0, TOK01);
`endif
    end
    de = 1'b0;
    if (edge_last) begin
      step();
      step();
      check("lastwarm_lu", lu, 1);
      check("lastwarm_lu_n", n_lu, 1);
    end else begin
      vs = 1'b0;
      repeat (3) begin
        step();
        check("waitvs_lu", lu, 0);
        check("waitvs_lu_n", n_lu, 0);
      end
      vs = 1'b1; hs = 1'b0; de = 1'b1;
      v0 = 10'h155; v1 = 10'h2AA; v2 = 10'h0F0;
      step();
      check("vsedge_lu", lu, 0);
`ifndef HDMI_GUARD_EN
      check("vsedge_ch0", ch0, TOK10);
      check("vsedge_ch1", ch1, TOK00);
`endif
      step();
      check("run_lu", lu, 1);
      check("run_lu_n", n_lu, 1);
`ifndef HDMI_GUARD_EN
      check("run_vid0", ch0, 10'h155);
      check("run_vid1", ch1, 10'h2AA);
      check("run_vid2", ch2, 10'h0F0);
`endif
    end
    de = 1'b0; vs = 1'b0; hs = 1'b1;
  endtask

`ifdef HDMI_GUARD_EN
  function automatic logic [9:0] word0(input int k);
    return 10'(k * 13 + 1);
  endfunction
  function automatic logic [9:0] word1(input int k);
    return 10'(k * 29 + 5);
  endfunction
  function automatic bit de_pat(input int k);
    return (k >= 20 && k <= 23) || (k >= 30 && k <= 33);
  endfunction
`endif

  initial begin
    rst_n = 1'b0; enable = 1'b0; de = 1'b0; hs = 1'b1; vs = 1'b0;
    v0 = '0; v1 = '0; v2 = '0;
    repeat (2) step();
    check("rst_ch0", ch0, TOK00);
    check("rst_ch1", ch1, TOK00);
    check("rst_ch2", ch2, TOK00);
    check("rst_oe", oe, 0);
    check("rst_lu", lu, 0);
    rst_n = 1'b1;
    step();
    check("idle_oe", oe, 0);
    check("idle_ch0", ch0, TOK00);

    // Bring-up with VSYNC edge in WAIT_VS
    bring_up(1'b0);

`ifndef HDMI_GUARD_EN
    // Sync tokens and video pass-through in RUN
    de = 1'b0; hs = 1'b1; vs = 1'b0;
    step();
    check("hs_ch0", ch0, TOK01);
    check("hs_ch1", ch1, TOK00);
    check("hs_ch2", ch2, TOK00);
    hs = 1'b0; vs = 1'b1;
    step();
    check("vs_ch0", ch0, TOK10);
    hs = 1'b1; vs = 1'b1;
    step();
    check("hsvs_ch0", ch0, TOK11);
    de = 1'b1; v0 = 10'h3FF; v1 = 10'h000; v2 = 10'h1A5;
    step();
    check("vid_b_ch0", ch0, 10'h3FF);
    check("vid_b_ch1", ch1, 10'h000);
    check("vid_b_ch2", ch2, 10'h1A5);
    vs = 1'b0;
`endif

    // Drop enable mid-line
    de = 1'b1; v0 = 10'h155; v1 = 10'h2AA; v2 = 10'h0F0;
    enable = 1'b0;
    step();
    check("drop_lu_still", lu, 1);
    step();
    check("drop_oe", oe, 0);
    check("drop_lu", lu, 0);
    check("drop_ch0", ch0, TOK00);
    check("drop_ch1", ch1, TOK00);
    check("drop_ch2", ch2, TOK00);
    de = 1'b0; vs = 1'b0; hs = 1'b1;
    bring_up(1'b0);

    // Reset during RUN
    rst_n = 1'b0;
    step();
    check("rstrun_oe", oe, 0);
    check("rstrun_lu", lu, 0);
    check("rstrun_ch0", ch0, TOK00);
    rst_n = 1'b1;
    bring_up(1'b0);

    // Reset during WARMUP; warm-up must restart from zero
    enable = 1'b0;
    repeat (2) step();
    enable = 1'b1;
    step();
    repeat (5) step();
    check("midwarm_oe", oe, 1);
    rst_n = 1'b0;
    step();
    check("rstwarm_oe", oe, 0);
    check("rstwarm_ch0", ch0, TOK00);
    rst_n = 1'b1;
    bring_up(1'b0);

    // VSYNC edge on the final warm-up cycle
    enable = 1'b0;
    repeat (2) step();
    bring_up(1'b1);

`ifdef HDMI_GUARD_EN
    // Long gap (20) gets preamble + guard; short gap (6) does not.
    de = 1'b0; hs = 1'b1; vs = 1'b0;
    repeat (12) step();
    for (int k = 0; k <= 50; k++) begin
      int j;
      logic [9:0] e0, e1, e2;
      de = de_pat(k);
      v0 = word0(k); v1 = word1(k); v2 = ~word0(k);
      step();
      j = k - 10;
      if (k >= 20 && k <= 27) begin
        e0 = TOK01; e1 = TOK01; e2 = TOK00;
      end else if (k == 28 || k == 29) begin
        e0 = 10'b1011001100; e1 = 10'b0100110011; e2 = 10'b1011001100;
      end else if (j >= 0 && de_pat(j)) begin
        e0 = word0(j); e1 = word1(j); e2 = ~word0(j);
      end else begin
        e0 = TOK01; e1 = TOK00; e2 = TOK00;
      end
      check("guard_ch0", ch0, e0);
      check("guard_ch1", ch1, e1);
      check("guard_ch2", ch2, e2);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_link_sequencer.md
Name: tmds_link_sequencer

Overview:
Pixel-clock-domain controller that drives the 10-bit parallel words into the three per-channel 10:1 TMDS serializers.
It sequences link bring-up: idle, then control-token warm-up, then alignment to a frame boundary, then live video.
During RUN it multiplexes pre-encoded video words (DE high) with control tokens carrying HSYNC/VSYNC (DE low).
It also produces the output-enable and link-status flags.

Parameters:
WARMUP_CYCLES, 1024, number of pixel clocks of control tokens sent before frame alignment; legal range 1..65535.
VS_POL, 1, active level of vsync_in (1 = active high); a VSYNC edge is the transition into the active level.

Ports:
pixel_clk  input  1  pixel clock; serializer 5x clock is phase-locked to it.
rst_n  input  1  synchronous reset, active low.
enable  input  1  link enable request.
de_in  input  1  data enable, aligned with tmds_vid_ch*.
hsync_in  input  1  horizontal sync, aligned with de_in.
vsync_in  input  1  vertical sync, aligned with de_in.
tmds_vid_ch0  input  10  encoded video word, blue channel.
tmds_vid_ch1  input  10  encoded video word, green channel.
tmds_vid_ch2  input  10  encoded video word, red channel.
tmds_ch0  output  10  parallel word to channel-0 serializer.
tmds_ch1  output  10  parallel word to channel-1 serializer.
tmds_ch2  output  10  parallel word to channel-2 serializer.
tmds_oe  output  1  pad output enable.
link_up  output  1  high while in RUN.

Behaviour:
- Single clock pixel_clk. Reset is synchronous, active-low: rst_n=0 sampled at a pixel_clk edge forces reset.
- Control tokens (c1,c0):
  - 00 = 10'b1101010100
  - 01 = 10'b0010101011
  - 10 = 10'b0101010100
  - 11 = 10'b1010101011
- Sync token: ch0 = token(c1=vsync,c0=hsync). ch1 = token 00. ch2 = token 00.
- Reset values:
  - state = IDLE.
  - tmds_ch0/1/2 = 10'b1101010100.
  - tmds_oe = 0, link_up = 0.
  - Warm-up counter = 0.
  - All internal delay stages are cleared to de=0, syncs inactive, data = 0.
- All outputs are registered. Base latency is 1 clock: the output at edge t+1 reflects the inputs sampled at edge t.
- States:
  - IDLE: tmds_oe=0; all channels output token 00. Go to WARMUP when enable=1.
  - WARMUP: tmds_oe=1; output sync tokens, ignoring de_in. The counter increments each cycle. After exactly WARMUP_CYCLES cycles in WARMUP, go to WAIT_VS.
  - WAIT_VS: output sync tokens, ignoring de_in. Go to RUN in the cycle a VSYNC edge is detected. The previous-vsync register is updated in every state, so an edge exactly at WARMUP exit is not missed.
  - RUN: link_up=1. If de=1, pass tmds_vid_ch0/1/2 through. If de=0, output sync tokens.
- enable=0 in any state: go to IDLE on the next edge. The counter clears, and outputs revert to IDLE values one cycle later. This includes mid-line, with no completion of the current line.
- rst_n=0 mid-operation: reset values take effect on the next edge, overriding the enable path.
- Re-enable from IDLE always repeats the full WARMUP and WAIT_VS sequence.
- de_in=1 coinciding with a VSYNC edge in WAIT_VS: the link enters RUN; that cycle's output is still a sync token, and de is honoured from the next cycle.

Optional Feature:
HDMI_GUARD_EN
- Defined:
  - The video/sync path gains a 10-stage delay, so latency becomes 11 clocks. State transitions still act on the undelayed inputs.
  - In RUN, the 10 output cycles immediately before the first active pixel of each DE burst are:
    - 8 preamble cycles: ch0 = sync token, ch1 = token 01, ch2 = token 00.
    - 2 guard cycles: ch0 = 10'b1011001100, ch1 = 10'b0100110011, ch2 = 10'b1011001100.
  - Insertion happens only if DE was low for at least 12 consecutive input cycles before its rising edge. Shorter gaps send plain sync tokens.
  - A DE burst that starts while the state is not RUN gets no insertion.
- Undefined: no delay line, latency 1, pure DVI token/video multiplexing.

Test Plan:
1. Reset then enable=1 with WARMUP_CYCLES=16 -> tmds_oe rises 1 clock after enable. Sync tokens for 16 cycles. Then WAIT_VS. link_up=0 until a VSYNC edge; link_up=1 on the edge after it.
2. RUN with hsync=1, vsync=0, de=0 -> tmds_ch0=10'b0010101011 and ch1=ch2=10'b1101010100. With de=1 and ch0/1/2 = 10'h155/10'h2AA/10'h0F0 -> the same words appear 1 clock later.
3. Deassert enable during an active line in RUN -> next edge state IDLE. The following cycle shows tmds_oe=0, link_up=0, all channels 10'b1101010100. Re-enable -> full warm-up is repeated.
4. rst_n=0 for 1 cycle during WARMUP and again during RUN -> reset values on the next edge. Warm-up count restarts from 0 after reset.
5. HDMI_GUARD_EN, 20-cycle blanking then DE burst -> outputs 8 preamble, then 2 guard, then the first pixel at input edge + 11. With 6-cycle blanking -> no preamble or guard, plain sync tokens.
6. VSYNC edge exactly on the last WARMUP cycle -> not lost. RUN is entered on that edge or the next with no frame skipped. VS_POL=0 -> a falling vsync_in triggers RUN.
